// File: rtl/image_scale_pkg.sv
// rtl/image_scale_pkg.sv - scale encodings, mask helper and counter type for image_scale_down_n
package image_scale_pkg;

  localparam logic [1:0] SCALE_1 = 2'd0;
  localparam logic [1:0] SCALE_2 = 2'd1;
  localparam logic [1:0] SCALE_4 = 2'd2;
  localparam logic [1:0] SCALE_8 = 2'd3;

  localparam int DIM_W_DEF = 16;

  typedef logic [DIM_W_DEF-1:0] dim_t;

  // Group mask for a log2 factor: (1<<scale)-1, at most 7
  function automatic logic [3:0] fn_mask(input logic [1:0] scale);
    return 4'((1 << scale) - 1);
  endfunction

endpackage

// File: rtl/image_scale_chan_acc.sv
// rtl/image_scale_chan_acc.sv - per-channel horizontal group accumulator with power-of-two divide
module image_scale_chan_acc #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [CW-1:0] pix_i,
  input  logic          valid_i,
  input  logic          start_i,
  input  logic          grp_end_i,
  input  logic [1:0]    shift_i,
  output logic [CW-1:0] avg_o
);

  logic [CW+2:0] acc_q;
  logic [CW+2:0] sum;

  // A line start discards whatever a dropped partial group left behind
  always_comb begin
    sum   = (start_i ? '0 : acc_q) + {3'b000, pix_i};
    avg_o = CW'(sum >> shift_i);
  end

  // Running sum restarts after every completed group
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
    end else if (valid_i) begin
      acc_q <= grp_end_i ? '0 : sum;
    end
  end

endmodule

// File: rtl/image_scale_down_n.sv
// rtl/image_scale_down_n.sv - power-of-two raster downscaler; IMAGE_SCALE_AVG_EN enables horizontal box filter
module image_scale_down_n
  import image_scale_pkg::*;
#(
  parameter int CH    = 1,
  parameter int CW    = 16,
  parameter int DIM_W = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [DIM_W-1:0]   width_i,
  input  logic [DIM_W-1:0]   height_i,
  input  logic [1:0]         scale_x_i,
  input  logic [1:0]         scale_y_i,
  input  logic [CH*CW-1:0]   tdata_i,
  input  logic               tvalid_i,
  output logic [CH*CW-1:0]   tdata_o,
  output logic               tvalid_o,
  output logic               frame_done_o
);

  logic [DIM_W-1:0] col, row;
  logic [DIM_W-1:0] width_q, height_q;
  logic [1:0]       sx_q, sy_q;

  logic             at_origin;
  logic [DIM_W-1:0] w_eff, h_eff, mx, my;
  logic [1:0]       sx_eff, sy_eff;
  logic             active, last_col, last_row, grp_end, emit;
  logic [CH*CW-1:0] pix_out;

  // The origin pixel uses live config so the frame's first pixel already obeys the new settings
  always_comb begin
    at_origin = (col == '0) && (row == '0);
    w_eff     = at_origin ? width_i   : width_q;
    h_eff     = at_origin ? height_i  : height_q;
    sx_eff    = at_origin ? scale_x_i : sx_q;
    sy_eff    = at_origin ? scale_y_i : sy_q;
    mx        = DIM_W'(fn_mask(sx_eff));
    my        = DIM_W'(fn_mask(sy_eff));
    active    = tvalid_i && (w_eff != '0) && (h_eff != '0);
    last_col  = (col == w_eff - DIM_W'(1));
    last_row  = (row == h_eff - DIM_W'(1));
    grp_end   = ((col & mx) == mx);
    emit      = active && grp_end && ((row & my) == my) && (col < (w_eff & ~mx));
  end

  // Raster position and per-frame config capture
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col      <= '0;
      row      <= '0;
      width_q  <= '0;
      height_q <= '0;
      sx_q     <= SCALE_1;
      sy_q     <= SCALE_1;
    end else if (active) begin
      if (at_origin) begin
        width_q  <= width_i;
        height_q <= height_i;
        sx_q     <= scale_x_i;
        sy_q     <= scale_y_i;
      end
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

`ifdef IMAGE_SCALE_AVG_EN
  for (genvar c = 0; c < CH; c++) begin : g_acc
    image_scale_chan_acc #(.CW(CW)) u_acc (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .pix_i     (tdata_i[c*CW +: CW]),
      .valid_i   (active),
      .start_i   (col == '0),
      .grp_end_i (grp_end),
      .shift_i   (sx_eff),
      .avg_o     (pix_out[c*CW +: CW])
    );
  end
`else
  assign pix_out = tdata_i;
`endif

  // Registered output stage; tdata_o holds its last value between strobes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tdata_o      <= '0;
      tvalid_o     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      tvalid_o     <= emit;
      frame_done_o <= active && last_col && last_row;
      if (emit) begin
        tdata_o <= pix_out;
      end
    end
  end

endmodule
